// File: rtl/cache_arbiter.sv
// Two-requester round-robin arbiter in front of a single-ported cache.
// One access in flight at a time; each completion is followed by a one-cycle GAP before re-arbitration.
module cache_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TMO_W  = 20
) (
    input  logic              cpu_clk,
    input  logic              reset,
    input  logic              m0_req_valid,
    input  logic              m0_req_is_write,
    input  logic [ADDR_W-1:0] m0_req_addr,
    input  logic [DATA_W-1:0] m0_req_data,
    output logic [DATA_W-1:0] m0_res_data,
    output logic              m0_res_ready,
    input  logic              m1_req_valid,
    input  logic              m1_req_is_write,
    input  logic [ADDR_W-1:0] m1_req_addr,
    input  logic [DATA_W-1:0] m1_req_data,
    output logic [DATA_W-1:0] m1_res_data,
    output logic              m1_res_ready,
    output logic              req_valid,
    output logic              req_is_write,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_data,
    input  logic [DATA_W-1:0] res_data,
    input  logic              res_ready,
    output logic              grant_id,
    output logic              timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [TMO_W-1:0] WDOG_MAX = {TMO_W{1'b1}};
    localparam logic [TMO_W-1:0] WDOG_ONE = {{(TMO_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    state_t            state_nxt_s;
    logic              any_req_s;
    logic              pick_s;
    logic              grant_s;
    logic              done_s;
    logic              last_r;
    logic              req_valid_r;
    logic              req_is_write_r;
    logic [ADDR_W-1:0] req_addr_r;
    logic [DATA_W-1:0] req_data_r;
    logic              grant_id_r;
    logic              m0_res_ready_r;
    logic              m1_res_ready_r;
    logic [DATA_W-1:0] m0_res_data_r;
    logic [DATA_W-1:0] m1_res_data_r;
    logic [TMO_W-1:0]  wdog_r;
    logic              timeout_r;

    // State register; reset abandons any access in flight.
    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; requests are only looked at in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) state_nxt_s = ST_BUSY;
                else           state_nxt_s = ST_IDLE;
            end
            ST_BUSY: begin
                if (res_ready) state_nxt_s = ST_GAP;
                else           state_nxt_s = ST_BUSY;
            end
            ST_GAP:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode: round-robin pick plus grant / completion strobes.
    always_comb begin
        any_req_s = m0_req_valid | m1_req_valid;
        if (m0_req_valid && m1_req_valid) begin
            pick_s = ~last_r;
        end else if (m1_req_valid) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
        grant_s = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: grant_s = any_req_s;
            ST_BUSY: done_s  = res_ready;
            ST_GAP:  done_s  = 1'b0;
            default: grant_s = 1'b0;
        endcase
    end

    // Cache-side request latch and requester-side completion registers.
    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            req_valid_r    <= 1'b0;
            req_is_write_r <= 1'b0;
            req_addr_r     <= {ADDR_W{1'b0}};
            req_data_r     <= {DATA_W{1'b0}};
            grant_id_r     <= 1'b0;
            last_r         <= 1'b1;
            m0_res_ready_r <= 1'b0;
            m1_res_ready_r <= 1'b0;
            m0_res_data_r  <= {DATA_W{1'b0}};
            m1_res_data_r  <= {DATA_W{1'b0}};
        end else begin
            req_valid_r    <= (state_nxt_s == ST_BUSY);
            m0_res_ready_r <= done_s & ~grant_id_r;
            m1_res_ready_r <= done_s & grant_id_r;
            if (grant_s) begin
                grant_id_r <= pick_s;
                if (pick_s) begin
                    req_is_write_r <= m1_req_is_write;
                    req_addr_r     <= m1_req_addr;
                    req_data_r     <= m1_req_data;
                end else begin
                    req_is_write_r <= m0_req_is_write;
                    req_addr_r     <= m0_req_addr;
                    req_data_r     <= m0_req_data;
                end
            end
            // Writes also return res_data so each requester sees its last completion.
            if (done_s) begin
                last_r <= grant_id_r;
                if (grant_id_r) m1_res_data_r <= res_data;
                else            m0_res_data_r <= res_data;
            end
        end
    end

    // Watchdog: counts BUSY cycles, raises a sticky flag when it saturates.
    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            wdog_r    <= {TMO_W{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            if (grant_s) begin
                wdog_r <= {TMO_W{1'b0}};
            end else if ((state_r == ST_BUSY) && (wdog_r != WDOG_MAX)) begin
                wdog_r <= wdog_r + WDOG_ONE;
            end
            timeout_r <= timeout_r | ((state_r == ST_BUSY) && (wdog_r == (WDOG_MAX - WDOG_ONE)));
        end
    end

    assign req_valid    = req_valid_r;
    assign req_is_write = req_is_write_r;
    assign req_addr     = req_addr_r;
    assign req_data     = req_data_r;
    assign grant_id     = grant_id_r;
    assign m0_res_ready = m0_res_ready_r;
    assign m1_res_ready = m1_res_ready_r;
    assign m0_res_data  = m0_res_data_r;
    assign m1_res_data  = m1_res_data_r;
    assign timeout      = timeout_r;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: table of single-requester accesses plus
// hand-written arbitration, stray-response, watchdog and reset sequences.
module tb_cache_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TW = 4;

    logic          cpu_clk = 1'b0;
    logic          reset;
    logic          m0_req_valid, m0_req_is_write, m1_req_valid, m1_req_is_write;
    logic [AW-1:0] m0_req_addr, m1_req_addr;
    logic [DW-1:0] m0_req_data, m1_req_data;
    logic [DW-1:0] m0_res_data, m1_res_data;
    logic          m0_res_ready, m1_res_ready;
    logic          req_valid, req_is_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic [DW-1:0] res_data;
    logic          res_ready;
    logic          grant_id, timeout;

    cache_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TMO_W(TW)) dut (
        .cpu_clk(cpu_clk), .reset(reset),
        .m0_req_valid(m0_req_valid), .m0_req_is_write(m0_req_is_write),
        .m0_req_addr(m0_req_addr), .m0_req_data(m0_req_data),
        .m0_res_data(m0_res_data), .m0_res_ready(m0_res_ready),
        .m1_req_valid(m1_req_valid), .m1_req_is_write(m1_req_is_write),
        .m1_req_addr(m1_req_addr), .m1_req_data(m1_req_data),
        .m1_res_data(m1_res_data), .m1_res_ready(m1_res_ready),
        .req_valid(req_valid), .req_is_write(req_is_write),
        .req_addr(req_addr), .req_data(req_data),
        .res_data(res_data), .res_ready(res_ready),
        .grant_id(grant_id), .timeout(timeout)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        logic          who;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            lat;
        logic [DW-1:0] rdata;
    } vec_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample just after the edge; every completion pulse is scored here.
    task automatic step();
        exp_t e;
        @(posedge cpu_clk);
        #1;
        cyc++;
        if (m0_res_ready || m1_res_ready) begin
            chk("dual_ready", 32'(m0_res_ready & m1_res_ready), 32'd0);
            chk("ready_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("ready_id", 32'(m1_res_ready), 32'(e.id));
                chk("res_data", e.id ? m1_res_data : m0_res_data, e.data);
            end
        end
    endtask

    task automatic wait_grant();
        int guard = 0;
        while (!req_valid && guard < 20) begin
            step();
            guard++;
        end
        chk("grant_wait", 32'(req_valid), 32'd1);
    endtask

    // Cache model: answers lat cycles after grant; counts cycles with a stable, valid request.
    task automatic serve(input int lat, input logic [DW-1:0] rdata, output logic gid,
                         output logic wr, output logic [AW-1:0] addr, output logic [DW-1:0] wd,
                         output int hi, output int start);
        hi = 0;
        wait_grant();
        gid = grant_id; wr = req_is_write; addr = req_addr; wd = req_data; start = cyc;
        for (int i = 0; i < lat; i++) begin
            if (req_valid && req_addr == addr && req_data == wd && req_is_write == wr) hi++;
            if (i == lat - 1) begin
                res_ready = 1'b1;
                res_data  = rdata;
            end
            step();
        end
        res_ready = 1'b0;
        chk("gap_req_valid", 32'(req_valid), 32'd0);
    endtask

    vec_t          vecs[4];
    logic          gid, wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] m0_last;
    int            hi, st, prev_st;

    initial begin
        vecs[0] = '{who: 1'b0, wr: 1'b1, addr: 32'h0,        wdata: 32'h1,    lat: 5, rdata: 32'h0000_00AA};
        vecs[1] = '{who: 1'b1, wr: 1'b0, addr: 32'h10,       wdata: 32'h0,    lat: 1, rdata: 32'hDEAD_BEEF};
        vecs[2] = '{who: 1'b0, wr: 1'b0, addr: 32'hFFFF_FFFC, wdata: 32'h0,   lat: 3, rdata: 32'h1234_5678};
        vecs[3] = '{who: 1'b1, wr: 1'b1, addr: 32'h20,       wdata: 32'hCAFE, lat: 2, rdata: 32'h0000_0055};

        reset = 1'b1;
        m0_req_valid = 1'b0; m0_req_is_write = 1'b0; m0_req_addr = 32'h0; m0_req_data = 32'h0;
        m1_req_valid = 1'b0; m1_req_is_write = 1'b0; m1_req_addr = 32'h0; m1_req_data = 32'h0;
        res_data = 32'h0; res_ready = 1'b0;
        step();
        step();
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        chk("rst_req_addr", req_addr, 32'h0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_m0_res_data", m0_res_data, 32'h0);
        chk("rst_m1_res_data", m1_res_data, 32'h0);
        reset = 1'b0;
        step();

        // Single-requester accesses
        for (int v = 0; v < 4; v++) begin
            if (vecs[v].who) begin
                m1_req_valid = 1'b1; m1_req_is_write = vecs[v].wr;
                m1_req_addr = vecs[v].addr; m1_req_data = vecs[v].wdata;
            end else begin
                m0_req_valid = 1'b1; m0_req_is_write = vecs[v].wr;
                m0_req_addr = vecs[v].addr; m0_req_data = vecs[v].wdata;
            end
            sb_q.push_back('{id: vecs[v].who, data: vecs[v].rdata});
            serve(vecs[v].lat, vecs[v].rdata, gid, wr, addr, wd, hi, st);
            chk("vec_grant_id", 32'(gid), 32'(vecs[v].who));
            chk("vec_is_write", 32'(wr), 32'(vecs[v].wr));
            chk("vec_addr", addr, vecs[v].addr);
            chk("vec_data", wd, vecs[v].wdata);
            chk("vec_busy_cycles", hi, vecs[v].lat);
            m0_req_valid = 1'b0;
            m1_req_valid = 1'b0;
            step();
        end

        // Simultaneous requests right after reset: m0 first
        reset = 1'b1;
        step();
        reset = 1'b0;
        m0_req_valid = 1'b1; m0_req_is_write = 1'b0; m0_req_addr = 32'h0;
        m1_req_valid = 1'b1; m1_req_is_write = 1'b0; m1_req_addr = 32'h10;
        sb_q.push_back('{id: 1'b0, data: 32'h1});
        sb_q.push_back('{id: 1'b1, data: 32'h7});
        serve(2, 32'h1, gid, wr, addr, wd, hi, st);
        chk("sim_first_id", 32'(gid), 32'd0);
        chk("sim_first_addr", addr, 32'h0);
        m0_req_valid = 1'b0;
        serve(2, 32'h7, gid, wr, addr, wd, hi, st);
        chk("sim_second_id", 32'(gid), 32'd1);
        chk("sim_second_addr", addr, 32'h10);
        m1_req_valid = 1'b0;
        chk("sim_m0_res_data", m0_res_data, 32'h1);
        chk("sim_m1_res_data", m1_res_data, 32'h7);
        step();

        // Both requesters continuously valid: strict alternation, >=3 cycles apart
        m0_req_valid = 1'b1; m0_req_addr = 32'h100;
        m1_req_valid = 1'b1; m1_req_addr = 32'h200;
        prev_st = -100;
        for (int i = 0; i < 6; i++) begin
            sb_q.push_back('{id: 1'(i % 2), data: 32'hA000 + 32'(i)});
            serve(1, 32'hA000 + 32'(i), gid, wr, addr, wd, hi, st);
            chk("rr_grant_id", 32'(gid), 32'(i % 2));
            chk("rr_addr", addr, (i % 2 == 1) ? 32'h200 : 32'h100);
            if (i > 0) chk("rr_spacing_ge3", 32'((st - prev_st) >= 3), 32'd1);
            prev_st = st;
        end
        m0_req_valid = 1'b0;
        m1_req_valid = 1'b0;
        m0_last = 32'hA004;
        step();

        // Stray res_ready in IDLE, then requester inputs change mid-BUSY
        res_ready = 1'b1; res_data = 32'hBAD0_BAD0;
        step();
        res_ready = 1'b0;
        chk("stray_m0_ready", 32'(m0_res_ready), 32'd0);
        chk("stray_m1_ready", 32'(m1_res_ready), 32'd0);
        chk("stray_m0_res_data", m0_res_data, m0_last);
        m0_req_valid = 1'b1; m0_req_is_write = 1'b0; m0_req_addr = 32'h40; m0_req_data = 32'h77;
        sb_q.push_back('{id: 1'b0, data: 32'h4444});
        wait_grant();
        m0_req_addr = 32'h999; m0_req_is_write = 1'b1; m0_req_data = 32'h5;
        step();
        step();
        chk("midbusy_req_valid", 32'(req_valid), 32'd1);
        chk("midbusy_addr", req_addr, 32'h40);
        chk("midbusy_is_write", 32'(req_is_write), 32'd0);
        chk("midbusy_data", req_data, 32'h77);
        res_ready = 1'b1; res_data = 32'h4444;
        step();
        res_ready = 1'b0;
        m0_req_valid = 1'b0;
        step();

        // Watchdog with TMO_W=4: flag after 15 BUSY cycles, completion still allowed
        m0_req_valid = 1'b1; m0_req_is_write = 1'b0; m0_req_addr = 32'h80;
        wait_grant();
        repeat (14) step();
        chk("tmo_before", 32'(timeout), 32'd0);
        step();
        chk("tmo_at_15", 32'(timeout), 32'd1);
        chk("tmo_still_busy", 32'(req_valid), 32'd1);
        repeat (3) step();
        sb_q.push_back('{id: 1'b0, data: 32'h35});
        res_ready = 1'b1; res_data = 32'h35;
        step();
        res_ready = 1'b0;
        m0_req_valid = 1'b0;
        chk("tmo_after_done", 32'(timeout), 32'd1);
        step();
        step();
        chk("tmo_sticky", 32'(timeout), 32'd1);

        // Reset mid-BUSY: immediate drop, no completion, m0 wins afterwards
        m1_req_valid = 1'b1; m1_req_is_write = 1'b0; m1_req_addr = 32'h90;
        wait_grant();
        step();
        reset = 1'b1;
        #1;
        chk("arst_req_valid", 32'(req_valid), 32'd0);
        chk("arst_grant_id", 32'(grant_id), 32'd0);
        chk("arst_timeout", 32'(timeout), 32'd0);
        res_ready = 1'b1; res_data = 32'hBB;
        step();
        reset = 1'b0;
        res_ready = 1'b0;
        chk("arst_m1_ready", 32'(m1_res_ready), 32'd0);
        m0_req_valid = 1'b1; m0_req_is_write = 1'b0; m0_req_addr = 32'hA0;
        sb_q.push_back('{id: 1'b0, data: 32'hC0});
        sb_q.push_back('{id: 1'b1, data: 32'hC1});
        serve(2, 32'hC0, gid, wr, addr, wd, hi, st);
        chk("post_rst_grant", 32'(gid), 32'd0);
        chk("post_rst_addr", addr, 32'hA0);
        m0_req_valid = 1'b0;
        serve(2, 32'hC1, gid, wr, addr, wd, hi, st);
        chk("post_rst_second", 32'(gid), 32'd1);
        m1_req_valid = 1'b0;
        step();
        chk("post_rst_m1_res_data", m1_res_data, 32'hC1);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
